// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data memory.
// It maps byte addresses to word indices, rejects bad accesses and routes read data back to the requester.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          AW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [31:0]   a_addr,
  input  logic [31:0]   a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [31:0]   b_addr,
  input  logic [31:0]   b_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [31:0]   a_rdata,
  output logic [31:0]   b_rdata,
  output logic          a_err,
  output logic          b_err,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_data,
  output logic          mem_wren,
  input  logic [31:0]   mem_q,
  output logic [15:0]   stall_cycles
);

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [31:0]   off_a, off_b;
  logic          bad_a, bad_b;
  logic [AW-1:0] idx_a, idx_b;
  logic          sel_b;

  logic        prio_q, prio_d;
  logic        rsp_v_q, rsp_v_d;
  logic        rsp_owner_q, rsp_owner_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_rd_q, rsp_rd_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    off_a = a_addr - BASE_ADDR;
    off_b = b_addr - BASE_ADDR;
    bad_a = (off_a[1:0] != 2'b00) || (off_a[31:AW+2] != '0);
    bad_b = (off_b[1:0] != 2'b00) || (off_b[31:AW+2] != '0);
    idx_a = off_a[AW+1:2];
    idx_b = off_b[AW+1:2];
  end

  // Grants are combinational so an unopposed CPU access never stalls.
  always_comb begin
    a_gnt = rst & a_req & (~b_req | (prio_q == PORT_A));
    b_gnt = rst & b_req & (~a_req | (prio_q == PORT_B));
  end

  // A bad or absent B access leaves the memory bus showing port A.
  always_comb begin
    sel_b    = b_gnt & ~bad_b;
    mem_addr = sel_b ? idx_b : idx_a;
    mem_data = sel_b ? b_wdata : a_wdata;
    mem_wren = (a_gnt & a_we & ~bad_a) | (b_gnt & b_we & ~bad_b);
  end

  always_comb begin
    prio_d = prio_q;
    if (a_gnt) prio_d = PORT_B;
    else if (b_gnt) prio_d = PORT_A;

    rsp_v_d     = a_gnt | b_gnt;
    rsp_owner_d = b_gnt ? PORT_B : PORT_A;
    rsp_err_d   = b_gnt ? bad_b : (a_gnt & bad_a);
    rsp_rd_d    = b_gnt ? ~b_we : (a_gnt & ~a_we);

    stall_d = stall_q;
    if (a_req && !a_gnt && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q      <= PORT_A;
      rsp_v_q     <= 1'b0;
      rsp_owner_q <= PORT_A;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
      stall_q     <= 16'd0;
    end else begin
      prio_q      <= prio_d;
      rsp_v_q     <= rsp_v_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
      stall_q     <= stall_d;
    end
  end

  always_comb begin
    a_rvalid = rsp_v_q & rsp_rd_q & (rsp_owner_q == PORT_A);
    b_rvalid = rsp_v_q & rsp_rd_q & (rsp_owner_q == PORT_B);
    a_err    = rsp_v_q & rsp_err_q & (rsp_owner_q == PORT_A);
    b_err    = rsp_v_q & rsp_err_q & (rsp_owner_q == PORT_B);
    a_rdata  = (a_rvalid && !rsp_err_q) ? mem_q : 32'd0;
    b_rdata  = (b_rvalid && !rsp_err_q) ? mem_q : 32'd0;
    stall_cycles = stall_q;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter placed in front of the single-port synchronous data memory. It shares the memory between the CPU load/store path (port A) and a debug/program-loader port (port B), translates byte addresses into word indices relative to the data segment base, rejects misaligned or out-of-range accesses, and routes one-cycle-latency read data back to the requester that issued the read. The CPU uses `a_gnt` to stall on conflict.

## Interface
- `BASE_ADDR`, default 32'h1001_0000: byte address of data-memory word 0.
- `AW`, default 10: memory word-address width (depth 2^AW words).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `a_req`, `b_req` input 1: access request, held until granted.
- `a_we`, `b_we` input 1: 1 = write, 0 = read.
- `a_addr`, `b_addr` input 32: byte address.
- `a_wdata`, `b_wdata` input 32: write data.
- `a_gnt`, `b_gnt` output 1: combinational grant for the current cycle.
- `a_rvalid`, `b_rvalid` output 1: read response valid, one cycle after grant.
- `a_rdata`, `b_rdata` output 32: read data, qualified by rvalid, else 0.
- `a_err`, `b_err` output 1: error pulse, one cycle after grant of a bad access.
- `mem_addr` output AW: word index to memory.
- `mem_data` output 32: write data to memory.
- `mem_wren` output 1: memory write enable.
- `mem_q` input 32: memory read data, valid the cycle after the address is presented.
- `stall_cycles` output 16: saturating count of cycles with `a_req & ~a_gnt`.

## Operation
- Offset: `off = addr - BASE_ADDR` (32-bit wrap). Bad access when `off[1:0] != 0` or `off[31:AW+2] != 0`. Word index is `off[AW+1:2]`.
- Arbitration uses a 1-bit round-robin pointer `prio`. Reset value: A.
  - Only one port requesting: grant that port.
  - Both requesting: grant the port named by `prio`.
  - On any grant, `prio` moves to the non-granted port.
- At most one grant per cycle. The grant is combinational from `req` and `prio`, so an unopposed CPU access sees no stall.
- Memory drive for the winner: `mem_addr` = its word index, `mem_data` = its wdata, `mem_wren` = `we & ~bad`. With no grant or a bad access, `mem_wren` = 0, and `mem_addr`/`mem_data` hold the port A values.
- Response pipeline: registers `rsp_v`, `rsp_owner`, `rsp_err`, `rsp_rd`, loaded every cycle from the current grant.
  - Next cycle, the owner sees `rvalid = rsp_v & rsp_rd`.
  - Next cycle, the owner sees `err = rsp_v & rsp_err`.
  - `rdata = mem_q` for a good read, 0 for a bad read.
  - Writes produce no rvalid. Bad writes still produce `err`.
- Back-to-back: a new grant may issue in the same cycle a previous read's response is presented. Throughput is one access per cycle.
- `stall_cycles` increments on each cycle with `a_req & ~a_gnt` and saturates at 16'hFFFF.

## Timing
- Reset (async assert, released synchronously by the environment): `prio`=A, `rsp_*`=0, `stall_cycles`=0.
  - All rvalid/err outputs are 0 and all rdata outputs are 0.
  - Grants are forced 0 while `rst` is low.
- Reset mid-operation: a read granted in the cycle before reset asserts yields no rvalid after release.
- Read latency: grant in cycle N, rvalid/rdata in cycle N+1 only (single-cycle pulse).
- A requester must hold its request fields stable until it is granted. Deasserting `req` before grant is legal and drops the request.
- Simultaneous events:
  - Write-after-read to the same word in consecutive cycles: the cycle-N+1 response returns the old data (memory read-before-write is not required, since the read completes first).
  - Same-cycle requests from both ports are serialized by `prio`. The loser is granted the next cycle at the latest, provided its `req` is still held.

## Test plan
- Reset, then `a_req` read at 0x1001_0008 alone: `a_gnt`=1 same cycle, `mem_addr`=2, `mem_wren`=0; next cycle `a_rvalid`=1 and `a_rdata`=`mem_q`.
- Both ports request continuously for 4 cycles: grants alternate A,B,A,B and `stall_cycles` ends at 2.
- B writes 0xDEADBEEF to 0x1001_0010, then A reads the same address: `mem_wren`=1 with `mem_addr`=4 on the write; A gets 0xDEADBEEF.
- A read at 0x1001_0006 (misaligned) and 0x0000_0000 (below base): granted, `mem_wren`=0, next cycle `a_err`=1, `a_rvalid`=1, `a_rdata`=0.
- Three back-to-back A reads at words 1,2,3: rvalid high for 3 consecutive cycles, with data matching each word in order.
- Assert `rst` low the cycle after a B read grant: no `b_rvalid` appears; after release all outputs are 0 and A wins the first conflict.
